// File: rtl/tx_beat_addr_gen.sv
// TX beat address generator: per-beat buffer addresses for GEM TX DMA packets,
// a length doorbell per completed packet, and an in-flight packet limit.
module tx_beat_addr_gen #(
  parameter int unsigned ADDR_WIDTH           = 12,
  parameter int unsigned BUS_WIDTH            = 32,
  parameter int unsigned BASE_ADDR            = 0,
  parameter int unsigned MAX_PKT_BYTES        = 2048,
  parameter int unsigned PACKET_COUNTER_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_beat_valid,
  output logic                            o_beat_ready,
  input  logic                            i_beat_last,
  output logic [ADDR_WIDTH-1:0]           o_addr_data,
  output logic                            o_addr_valid,
  input  logic                            i_addr_ready,
  output logic                            o_pkt_done,
  output logic [ADDR_WIDTH:0]             o_pkt_len,
  input  logic                            i_pkt_consumed,
  output logic [PACKET_COUNTER_WIDTH:0]   o_outstanding,
  output logic                            o_overflow
);

  localparam int unsigned BEAT_BYTES      = BUS_WIDTH / 8;
  localparam int unsigned OFF_W           = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W           = PACKET_COUNTER_WIDTH + 1;
  localparam int unsigned MAX_OUTSTANDING = 1 << PACKET_COUNTER_WIDTH;

  localparam logic [OFF_W-1:0]      BEAT_OFF = OFF_W'(BEAT_BYTES);
  localparam logic [OFF_W-1:0]      MAX_OFF  = OFF_W'(MAX_PKT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [OFF_W-1:0]      r_offset;
  logic [OFF_W-1:0]      w_offset_nxt;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      w_outstanding_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_data;
  logic                  r_addr_valid;
  logic                  r_addr_last;
  logic                  r_pkt_done;
  logic [ADDR_WIDTH:0]   r_pkt_len;
  logic                  r_overflow;

  logic                  w_ready;
  logic                  w_stage_free;
  logic                  w_accept;
  logic                  w_addr_hs;
  logic                  w_emit;
  logic [ADDR_WIDTH-1:0] w_emit_addr;
  logic                  w_emit_last;
  logic                  w_start;
  logic                  w_release;
  logic                  w_set_ovf;
  logic                  w_consume;
  logic [CNT_W:0]        w_cnt_up;
  logic [CNT_W:0]        w_cnt_dn;
  logic [ADDR_WIDTH:0]   w_pkt_len;

  assign w_stage_free = !r_addr_valid || i_addr_ready;
  assign w_accept     = i_beat_valid && w_ready;
  assign w_addr_hs    = r_addr_valid && i_addr_ready;
  assign w_consume    = i_pkt_consumed && (r_outstanding != '0);
  assign w_pkt_len    = {1'b0, r_addr_data - BASE} + (ADDR_WIDTH + 1)'(BEAT_BYTES);

  // Start, consume and drop-release are summed in a single update.
  assign w_cnt_up          = {1'b0, r_outstanding} + (CNT_W + 1)'(w_start);
  assign w_cnt_dn          = (CNT_W + 1)'(w_consume) + (CNT_W + 1)'(w_release);
  assign w_outstanding_nxt = (w_cnt_up > w_cnt_dn) ? CNT_W'(w_cnt_up - w_cnt_dn) : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_ready      = 1'b0;
    w_emit       = 1'b0;
    w_emit_addr  = BASE;
    w_emit_last  = 1'b0;
    w_start      = 1'b0;
    w_release    = 1'b0;
    w_set_ovf    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = !reset && w_stage_free && (r_outstanding < MAX_CNT);
        if (w_accept) begin
          w_start     = 1'b1;
          w_emit      = 1'b1;
          w_emit_last = i_beat_last;
          if (i_beat_last) begin
            w_offset_nxt = '0;
          end else begin
            w_offset_nxt = BEAT_OFF;
            w_state_nxt  = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_ready = !reset && w_stage_free;
        if (w_accept) begin
          if (r_offset < MAX_OFF) begin
            w_emit       = 1'b1;
            w_emit_addr  = BASE + r_offset[ADDR_WIDTH-1:0];
            w_emit_last  = i_beat_last;
            w_offset_nxt = r_offset + BEAT_OFF;
            if (i_beat_last) begin
              w_offset_nxt = '0;
              w_state_nxt  = S_IDLE;
            end
          end else begin
            // Buffer full: this beat and the rest of the packet are dropped.
            w_set_ovf = 1'b1;
            if (i_beat_last) begin
              w_release    = 1'b1;
              w_offset_nxt = '0;
              w_state_nxt  = S_IDLE;
            end else begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        w_ready = !reset;
        if (w_accept && i_beat_last) begin
          w_release    = 1'b1;
          w_offset_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_offset      <= '0;
      r_outstanding <= '0;
      r_addr_data   <= '0;
      r_addr_valid  <= 1'b0;
      r_addr_last   <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_pkt_len     <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_offset      <= w_offset_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_stage_free) begin
        r_addr_valid <= w_emit;
        if (w_emit) begin
          r_addr_data <= w_emit_addr;
          r_addr_last <= w_emit_last;
        end
      end
      r_pkt_done <= w_addr_hs && r_addr_last;
      if (w_addr_hs && r_addr_last) begin
        r_pkt_len <= w_pkt_len;
      end
      if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_beat_ready  = w_ready;
  assign o_addr_data   = r_addr_data;
  assign o_addr_valid  = r_addr_valid;
  assign o_pkt_done    = r_pkt_done;
  assign o_pkt_len     = r_pkt_len;
  assign o_outstanding = r_outstanding;
  assign o_overflow    = r_overflow;

endmodule
